mem_stage_pipe: RTL and testbench

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

---
 rtl/mem_stage_pipe.sv | 156 +++++++++++++++
 tb/tb_mem_stage_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: M/WB pipeline stage with synchronous data memory and multi-cycle load FSM.
// Optional feature macro: MEM_BOUNDS_CHECK_EN flags out-of-range addresses via mem_err_o.
module mem_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int A3_W    = 4,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] RD2_i,
    input  logic [DATA_W-1:0] AluResult_i,
    input  logic [A3_W-1:0]   A3_i,
    input  logic              RF_WE_i,
    input  logic              MemWE_i,
    input  logic              WBSelect_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic              RF_WE_o,
    output logic              WBSelect_o,
    output logic [DATA_W-1:0] AluResult_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [A3_W-1:0]   A3_o,
    output logic              mem_err_o
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic       LONG = (MEM_LAT > 1);
    localparam logic [1:0] LAST = 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_valid_m;
    logic [DATA_W-1:0] r_rd2_m;
    logic [DATA_W-1:0] r_alu_m;
    logic [A3_W-1:0]   r_a3_m;
    logic              r_rfwe_m;
    logic              r_memwe_m;
    logic              r_wbsel_m;
    logic              r_valid_o;
    logic              r_rfwe_o;
    logic              r_wbsel_o;
    logic [DATA_W-1:0] r_alu_o;
    logic [DATA_W-1:0] r_rdata_o;
    logic [A3_W-1:0]   r_a3_o;
    logic              r_err_o;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [AW-1:0] w_addr;
    logic          w_load_m;
    logic          w_store_m;
    logic          w_err;
    logic          w_done;
    logic          w_busy;
    logic          w_cap;
    logic          w_wb_v;

    assign w_addr    = r_alu_m[AW-1:0];
    assign w_load_m  = r_valid_m & r_wbsel_m & ~r_memwe_m;
    assign w_store_m = r_valid_m & r_memwe_m;
`ifdef MEM_BOUNDS_CHECK_EN
    assign w_err     = r_valid_m & (|r_alu_m[DATA_W-1:AW]);
`else
    assign w_err     = 1'b0;
`endif
    // The last WAIT cycle is the one whose closing edge hands the load to WB, so it is not busy.
    assign w_done    = (r_state == S_WAIT) & (r_cnt == LAST);
    assign w_busy    = (r_state == S_IDLE) ? (LONG & w_load_m) : ~w_done;
    assign w_cap     = ~stall_i & ~w_busy;
    assign w_wb_v    = r_valid_m & ~w_busy & ~flush_i;

    assign busy_o      = w_busy;
    assign valid_o     = r_valid_o;
    assign RF_WE_o     = r_rfwe_o;
    assign WBSelect_o  = r_wbsel_o;
    assign AluResult_o = r_alu_o;
    assign ReadData_o  = r_rdata_o;
    assign A3_o        = r_a3_o;
    assign mem_err_o   = r_err_o;

    // M register: capture when neither stalled nor busy; flush kills the M slot unconditionally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid_m <= 1'b0;
            r_rd2_m   <= '0;
            r_alu_m   <= '0;
            r_a3_m    <= '0;
            r_rfwe_m  <= 1'b0;
            r_memwe_m <= 1'b0;
            r_wbsel_m <= 1'b0;
        end else begin
            if (flush_i)
                r_valid_m <= 1'b0;
            else if (w_cap)
                r_valid_m <= valid_i;
            if (w_cap) begin
                r_rd2_m   <= RD2_i;
                r_alu_m   <= AluResult_i;
                r_a3_m    <= A3_i;
                r_rfwe_m  <= RF_WE_i;
                r_memwe_m <= MemWE_i;
                r_wbsel_m <= WBSelect_i;
            end
        end
    end

    // Access FSM: a long load spends MEM_LAT-1 cycles in WAIT; flush aborts, stall freezes.
    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (!stall_i) begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (LONG && w_load_m)
                    r_state <= S_WAIT;
            end else if (w_done) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Data memory write: a store commits once, on its non-stalled M edge; contents are never reset.
    always_ff @(posedge CLK) begin
        if (!RST && !stall_i && !flush_i && w_store_m && !w_err)
            r_mem[w_addr] <= r_rd2_m;
    end

    // WB register: takes the M instruction, or a bubble while busy or flushed; holds under stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid_o <= 1'b0;
            r_rfwe_o  <= 1'b0;
            r_wbsel_o <= 1'b0;
            r_alu_o   <= '0;
            r_rdata_o <= '0;
            r_a3_o    <= '0;
            r_err_o   <= 1'b0;
        end else if (!stall_i) begin
            r_valid_o <= w_wb_v;
            r_rfwe_o  <= w_wb_v & r_rfwe_m;
            r_wbsel_o <= w_wb_v & r_wbsel_m;
            r_alu_o   <= r_alu_m;
            r_rdata_o <= (w_wb_v && w_load_m && !w_err) ? r_mem[w_addr] : '0;
            r_a3_o    <= r_a3_m;
            r_err_o   <= w_wb_v & w_err;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of mem_stage_pipe with MEM_LAT=1 (ua) and MEM_LAT=3 (ub).
module tb_mem_stage_pipe;
    logic        clk = 1'b0;
    logic        rst, valid_i, rfwe_i, memwe_i, wbsel_i, stall_i, flush_i;
    logic [31:0] rd2_i, alu_i;
    logic [3:0]  a3_i;
    logic        a_busy, a_valid, a_we, a_sel, a_err;
    logic [31:0] a_alu, a_rd;
    logic [3:0]  a_a3;
    logic        b_busy, b_valid, b_we, b_sel, b_err;
    logic [31:0] b_alu, b_rd;
    logic [3:0]  b_a3;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.MEM_LAT(1)) ua (
        .CLK(clk), .RST(rst), .valid_i(valid_i), .RD2_i(rd2_i), .AluResult_i(alu_i),
        .A3_i(a3_i), .RF_WE_i(rfwe_i), .MemWE_i(memwe_i), .WBSelect_i(wbsel_i),
        .stall_i(stall_i), .flush_i(flush_i), .busy_o(a_busy), .valid_o(a_valid),
        .RF_WE_o(a_we), .WBSelect_o(a_sel), .AluResult_o(a_alu), .ReadData_o(a_rd),
        .A3_o(a_a3), .mem_err_o(a_err)
    );

    mem_stage_pipe #(.MEM_LAT(3)) ub (
        .CLK(clk), .RST(rst), .valid_i(valid_i), .RD2_i(rd2_i), .AluResult_i(alu_i),
        .A3_i(a3_i), .RF_WE_i(rfwe_i), .MemWE_i(memwe_i), .WBSelect_i(wbsel_i),
        .stall_i(stall_i), .flush_i(flush_i), .busy_o(b_busy), .valid_o(b_valid),
        .RF_WE_o(b_we), .WBSelect_o(b_sel), .AluResult_o(b_alu), .ReadData_o(b_rd),
        .A3_o(b_a3), .mem_err_o(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [3:0] a3, input logic rfwe, input logic memwe, input logic wbsel);
        valid_i = v;
        alu_i   = alu;
        rd2_i   = rd2;
        a3_i    = a3;
        rfwe_i  = rfwe;
        memwe_i = memwe;
        wbsel_i = wbsel;
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        idle();
        tick(); tick();
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_rd", a_rd, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        drive(1'b1, 32'd5, 32'hDEADBEEF, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 32'd5, 32'h0, 4'd3, 1'b1, 1'b0, 1'b1); tick();
        chk("st_valid", a_valid, 1);
        chk("st_we", a_we, 0);
        chk("st_rd", a_rd, 0);
        chk("st_alu", a_alu, 5);
        idle();
        chk("l1_busy", a_busy, 0);
        tick();
        chk("ld_valid", a_valid, 1);
        chk("ld_data", a_rd, 32'hDEADBEEF);
        chk("ld_we", a_we, 1);
        chk("ld_a3", a_a3, 3);
        chk("ld_sel", a_sel, 1);

        drive(1'b1, 32'h55, 32'h99, 4'd9, 1'b1, 1'b0, 1'b0); tick();
        idle(); tick();
        chk("alu_valid", a_valid, 1);
        chk("alu_res", a_alu, 32'h55);
        chk("alu_rd", a_rd, 0);
        chk("alu_we", a_we, 1);
        chk("alu_a3", a_a3, 9);

        drive(1'b1, 32'h11, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 32'd10, 32'hCAFE, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        stall_i = 1'b1;
        drive(1'b1, 32'd10, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_valid", a_valid, 1);
            chk("stl_alu", a_alu, 32'h11);
        end
        stall_i = 1'b0;
        tick();
        chk("rs_st_alu", a_alu, 10);
        chk("rs_st_we", a_we, 0);
        idle(); tick();
        chk("rs_ld_data", a_rd, 32'hCAFE);
        chk("rs_ld_a3", a_a3, 2);

        drive(1'b1, 32'h22, 32'h0, 4'd4, 1'b1, 1'b0, 1'b0); tick();
        flush_i = 1'b1; idle(); tick(); flush_i = 1'b0;
        chk("fl_valid", a_valid, 0);
        chk("fl_we", a_we, 0);
        tick();
        chk("fl_valid2", a_valid, 0);

        drive(1'b1, 32'h0, 32'h11, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h100, 32'h77, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("ob_st0_err", a_err, 0);
        drive(1'b1, 32'h0, 32'h0, 4'd5, 1'b1, 1'b0, 1'b1); tick();
        chk("ob_valid", a_valid, 1);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("ob_err", a_err, 1);
`else
        chk("ob_err", a_err, 0);
`endif
        idle(); tick();
`ifdef MEM_BOUNDS_CHECK_EN
        chk("ob_addr0", a_rd, 32'h11);
`else
        chk("ob_addr0", a_rd, 32'h77);
`endif

        rst = 1'b1; idle(); tick(); rst = 1'b0;
        chk("l3_rst_busy", b_busy, 0);
        drive(1'b1, 32'd7, 32'h12, 4'd0, 1'b0, 1'b1, 1'b0); tick();
        idle(); tick();
        drive(1'b1, 32'd7, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1); tick();
        idle();
        chk("l3_busy0", b_busy, 1);
        tick();
        chk("l3_bub1", b_valid, 0);
        chk("l3_busy1", b_busy, 1);
        tick();
        chk("l3_bub2", b_valid, 0);
        chk("l3_busy2", b_busy, 0);
        tick();
        chk("l3_valid", b_valid, 1);
        chk("l3_data", b_rd, 32'h12);
        chk("l3_a3", b_a3, 6);
        chk("l3_we", b_we, 1);

        drive(1'b1, 32'd7, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1); tick();
        idle(); tick(); tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("fw_valid", b_valid, 0);
        chk("fw_busy", b_busy, 0);
        tick();
        chk("fw_valid2", b_valid, 0);
        chk("fw_busy2", b_busy, 0);

        drive(1'b1, 32'd7, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1); tick();
        idle(); tick();
        stall_i = 1'b1; tick(); tick();
        chk("sw_busy", b_busy, 1);
        chk("sw_valid", b_valid, 0);
        stall_i = 1'b0; tick();
        chk("sw_busy2", b_busy, 0);
        chk("sw_valid2", b_valid, 0);
        tick();
        chk("sw_valid3", b_valid, 1);
        chk("sw_data", b_rd, 32'h12);

        drive(1'b1, 32'd7, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1); tick();
        idle(); tick();
        rst = 1'b1; tick();
        chk("rw_busy", b_busy, 0);
        chk("rw_valid", b_valid, 0);
        chk("rw_rd", b_rd, 0);
        chk("rw_a3", b_a3, 0);
        chk("rw_alu", b_alu, 0);
        chk("rw_we", b_we, 0);
        chk("rw_sel", b_sel, 0);
        chk("rw_err", b_err, 0);
        rst = 1'b0; tick(); tick();
        chk("rw_valid2", b_valid, 0);
        chk("rw_busy2", b_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
